pipe_control_unit: RTL and testbench
====================================

# pipe_control_unit

Pipelined successor to the single-cycle opcode decoder. Decodes the ID-stage opcode into WB/MEM/EX control bundles and carries them through the ID/EX, EX/MEM and MEM/WB control registers. Detects load-use hazards (stall plus bubble) and taken branches (flush), and keeps saturating stall and flush event counters. Sits between the IF/ID register and the datapath stage registers of the pipelined MIPS core.

## Interface
Parameters:
- REG_W, 5, register-specifier width.
- ENABLE_ADDI, 1, when 1 decode ADDI (001000); when 0 ADDI is illegal.
- CNT_W, 16, width of the stall and flush counters.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- id_valid  in  1  the IF/ID register holds a real instruction.
- id_opcode  in  6  instr[31:26] from IF/ID.
- id_rs  in  REG_W  instr[25:21] from IF/ID.
- id_rt  in  REG_W  instr[20:16] from IF/ID.
- mem_zero  in  1  ALU zero flag held in the EX/MEM datapath register.
- ex_ctrl  out  4  ID/EX bundle {RegDst, ALUOp[1:0], ALUSrc}.
- mem_ctrl  out  3  EX/MEM bundle {Branch, MemRead, MemWrite}.
- wb_ctrl  out  2  MEM/WB bundle {RegWrite, MemtoReg}.
- ex_rt  out  REG_W  rt latched alongside ex_ctrl.
- stall  out  1  combinational; hold PC and IF/ID this cycle.
- flush  out  1  combinational; zero IF/ID this cycle.
- illegal_op  out  1  registered; the instruction now in EX had an undecoded opcode.
- stall_count  out  CNT_W  saturating count of stall cycles.
- flush_count  out  CNT_W  saturating count of flush cycles.

## Operation
Decode, as {WB, MEM, EX}:
- R-format 000000: WB 10, MEM 000, EX 1100.
- LW 100011: WB 11, MEM 010, EX 0001.
- SW 101011: WB 00, MEM 001, EX 0001.
- BEQ 000100: WB 00, MEM 100, EX 0010.
- ADDI 001000 (ENABLE_ADDI=1): WB 10, MEM 000, EX 0001.
- Any other opcode with id_valid=1: all zeros and illegal_next=1.
- id_valid=0: all zeros and illegal_next=0.

Internal state:
- id_ex_wb[1:0] and id_ex_mem[2:0] are held alongside ex_ctrl and advance with it.
- The current ID/EX MemRead bit is id_ex_mem[1].

Hazard and flush conditions:
- hazard = id_valid & id_ex_mem[1] & (ex_rt==id_rs | ex_rt==id_rt).
- taken = mem_ctrl[2] & mem_zero.
- flush = taken.
- stall = hazard & ~taken. A flush overrides a stall.

Register update, each clock edge:
- taken=1: ID/EX and EX/MEM load zeros. MEM/WB loads the EX/MEM wb bundle (the branch has no write-back). illegal_op goes to 0.
- else stall=1: ID/EX loads zeros (bubble), and illegal_op goes to 0. EX/MEM loads the ID/EX bundles. MEM/WB loads the EX/MEM wb bundle.
- else (normal): ID/EX loads the decode result plus id_rt. illegal_op takes illegal_next. The later stages shift as above.
- ex_rt goes to 0 whenever ID/EX is bubbled or flushed.

Counters:
- stall_count increments on each cycle with stall=1.
- flush_count increments on each cycle with flush=1.
- Both saturate at all-ones and never wrap.

## Timing
- Reset: every output register is 0, i.e. ex_ctrl, mem_ctrl, wb_ctrl, ex_rt, illegal_op and both counters. With no valid instruction in the pipeline, stall and flush are therefore 0.
- Reset takes effect immediately and asynchronously, including in the middle of a stall or flush. The first edge after reset deasserts behaves as a normal cycle.
- Latency from id_opcode to ex_ctrl is 1 cycle. mem_ctrl follows 1 cycle later and wb_ctrl 1 cycle after that.
- stall and flush are combinational from same-cycle inputs and register state; they have no registered delay.
- Load-use: LW in EX with a dependent instruction in ID gives exactly one stall cycle. The following cycle the LW is in MEM, so the hazard clears and the held instruction decodes.
- Branch: taken is known with BEQ in MEM. Exactly one flush cycle removes 3 instructions: the one in IF/ID (external), ID/EX and EX/MEM.
- Simultaneous hazard and taken: stall=0, flush=1, and stall_count does not increment.
- A counter at all-ones stays at all-ones when its event recurs.

## Test plan
- Reset then decode: assert reset mid-run, then check all outputs are 0. Drive id_valid=1 with R, LW, SW, BEQ, ADDI in successive cycles. ex_ctrl must read 1100, 0001, 0001, 0010, 0001 one cycle later, and mem_ctrl/wb_ctrl must follow with the table values at +2 and +3 cycles.
- Illegal opcode: drive 111111 with id_valid=1. One cycle later all ex_ctrl bits are 0 and illegal_op=1. Repeat with ENABLE_ADDI=0 and opcode 001000: same result.
- Load-use: LW with rt=5, then R-format with rs=5. stall=1 for exactly one cycle, ex_ctrl=0000 (bubble) the next cycle, stall_count=1, and the R-format reaches EX one cycle late.
- No false hazard: SW with rt=5, then R-format with rs=5 gives stall=0. LW with rt=5, then an instruction with id_valid=0 and rs=5 gives stall=0.
- Branch taken: BEQ, then two R-formats; when BEQ reaches MEM drive mem_zero=1. flush=1 for one cycle, and next cycle ex_ctrl=0 and mem_ctrl=0. With mem_zero=0 there is no flush and the pipeline is unchanged.
- Priority and saturation: with CNT_W=2, create a hazard in the same cycle as a taken branch; stall=0 and flush=1. Then force 5 stall cycles: stall_count reads 3 and stays at 3.

Source files
------------

// File: rtl/pipe_control_unit.sv
// Pipelined control unit: decodes the ID-stage opcode and carries the control bundles
// through ID/EX, EX/MEM and MEM/WB, with load-use stall, branch flush and event counters.
module pipe_control_unit #(
    parameter int REG_W       = 5,
    parameter bit ENABLE_ADDI = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             mem_zero,
    output logic [3:0]       ex_ctrl,
    output logic [2:0]       mem_ctrl,
    output logic [1:0]       wb_ctrl,
    output logic [REG_W-1:0] ex_rt,
    output logic             stall,
    output logic             flush,
    output logic             illegal_op,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic [3:0]       w_dec_ex;
    logic [2:0]       w_dec_mem;
    logic [1:0]       w_dec_wb;
    logic             w_illegal_next;
    logic             w_hazard;
    logic             w_taken;
    logic             w_stall;

    logic [3:0]       r_ex_ctrl;
    logic [2:0]       r_id_ex_mem;
    logic [1:0]       r_id_ex_wb;
    logic [REG_W-1:0] r_ex_rt;
    logic             r_illegal;
    logic [2:0]       r_mem_ctrl;
    logic [1:0]       r_ex_mem_wb;
    logic [1:0]       r_wb_ctrl;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;

    always_comb begin
        w_dec_ex       = 4'b0000;
        w_dec_mem      = 3'b000;
        w_dec_wb       = 2'b00;
        w_illegal_next = 1'b0;
        if (id_valid) begin
            case (id_opcode)
                OP_RTYPE: begin w_dec_wb = 2'b10; w_dec_mem = 3'b000; w_dec_ex = 4'b1100; end
                OP_LW:    begin w_dec_wb = 2'b11; w_dec_mem = 3'b010; w_dec_ex = 4'b0001; end
                OP_SW:    begin w_dec_wb = 2'b00; w_dec_mem = 3'b001; w_dec_ex = 4'b0001; end
                OP_BEQ:   begin w_dec_wb = 2'b00; w_dec_mem = 3'b100; w_dec_ex = 4'b0010; end
                OP_ADDI: begin
                    if (ENABLE_ADDI) begin
                        w_dec_wb  = 2'b10;
                        w_dec_mem = 3'b000;
                        w_dec_ex  = 4'b0001;
                    end else begin
                        w_illegal_next = 1'b1;
                    end
                end
                default: w_illegal_next = 1'b1;
            endcase
        end
    end

    // A load in EX whose destination feeds the instruction in ID must wait one cycle.
    assign w_hazard = id_valid & r_id_ex_mem[1] & ((r_ex_rt == id_rs) | (r_ex_rt == id_rt));
    assign w_taken  = r_mem_ctrl[2] & mem_zero;
    assign w_stall  = w_hazard & ~w_taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_ctrl   <= '0;
            r_id_ex_mem <= '0;
            r_id_ex_wb  <= '0;
            r_ex_rt     <= '0;
            r_illegal   <= 1'b0;
            r_mem_ctrl  <= '0;
            r_ex_mem_wb <= '0;
            r_wb_ctrl   <= '0;
        end else begin
            r_wb_ctrl <= r_ex_mem_wb;
            if (w_taken) begin
                r_ex_ctrl   <= '0;
                r_id_ex_mem <= '0;
                r_id_ex_wb  <= '0;
                r_ex_rt     <= '0;
                r_illegal   <= 1'b0;
                r_mem_ctrl  <= '0;
                r_ex_mem_wb <= '0;
            end else begin
                r_mem_ctrl  <= r_id_ex_mem;
                r_ex_mem_wb <= r_id_ex_wb;
                if (w_stall) begin
                    r_ex_ctrl   <= '0;
                    r_id_ex_mem <= '0;
                    r_id_ex_wb  <= '0;
                    r_ex_rt     <= '0;
                    r_illegal   <= 1'b0;
                end else begin
                    r_ex_ctrl   <= w_dec_ex;
                    r_id_ex_mem <= w_dec_mem;
                    r_id_ex_wb  <= w_dec_wb;
                    r_ex_rt     <= id_rt;
                    r_illegal   <= w_illegal_next;
                end
            end
        end
    end

    // Event counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_stall && !(&r_stall_count))
                r_stall_count <= r_stall_count + CNT_W'(1);
            if (w_taken && !(&r_flush_count))
                r_flush_count <= r_flush_count + CNT_W'(1);
        end
    end

    assign ex_ctrl     = r_ex_ctrl;
    assign mem_ctrl    = r_mem_ctrl;
    assign wb_ctrl     = r_wb_ctrl;
    assign ex_rt       = r_ex_rt;
    assign illegal_op  = r_illegal;
    assign stall       = w_stall;
    assign flush       = w_taken;
    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Scoreboard bench for pipe_control_unit: a default instance plus one with ADDI disabled
// and 2-bit counters, both fed the same directed instruction stream.
module tb_pipe_control_unit;

    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] BAD  = 6'b111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0;
    logic [5:0] id_opcode = 6'd0;
    logic [4:0] id_rs = 5'd0;
    logic [4:0] id_rt = 5'd0;
    logic       mem_zero = 1'b0;

    logic [3:0]  ex_ctrl, ex_ctrl2;
    logic [2:0]  mem_ctrl, mem_ctrl2;
    logic [1:0]  wb_ctrl, wb_ctrl2;
    logic [4:0]  ex_rt, ex_rt2;
    logic        stall, stall2, flush, flush2, illegal_op, illegal_op2;
    logic [15:0] stall_count, flush_count;
    logic [1:0]  stall_count2, flush_count2;

    always #10 clk = ~clk;

    pipe_control_unit dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .mem_zero(mem_zero),
        .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl), .ex_rt(ex_rt),
        .stall(stall), .flush(flush), .illegal_op(illegal_op),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipe_control_unit #(.REG_W(5), .ENABLE_ADDI(1'b0), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .mem_zero(mem_zero),
        .ex_ctrl(ex_ctrl2), .mem_ctrl(mem_ctrl2), .wb_ctrl(wb_ctrl2), .ex_rt(ex_rt2),
        .stall(stall2), .flush(flush2), .illegal_op(illegal_op2),
        .stall_count(stall_count2), .flush_count(flush_count2)
    );

    typedef struct {
        int         idx;
        logic [3:0] ex;
        logic [2:0] mem;
        logic [1:0] wb;
        int         rt;
        logic       ill;
        logic       st;
        logic       fl;
        int         sc;
        int         fc;
        logic       ill2;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   step_no = 0;

    task automatic check(input int idx, input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL step %0d %s: got %0d, expected %0d", idx, name, act, req);
        end
    endtask

    task automatic push_exp(input logic [3:0] ex, input logic [2:0] mem, input logic [1:0] wb,
                            input int ert, input logic ill, input logic st, input logic fl,
                            input int sc, input int fc, input logic ill2);
        exp_t e;
        step_no++;
        e.idx = step_no; e.ex = ex; e.mem = mem; e.wb = wb; e.rt = ert; e.ill = ill;
        e.st = st; e.fl = fl; e.sc = sc; e.fc = fc; e.ill2 = ill2;
        q.push_back(e);
    endtask

    // Drive one ID-stage slot and record what the outputs must show during that cycle.
    task automatic step(input logic v, input logic [5:0] op, input int rs, input int rt,
                        input logic z, input logic [3:0] ex, input logic [2:0] mem,
                        input logic [1:0] wb, input int ert, input logic ill, input logic st,
                        input logic fl, input int sc, input int fc, input logic ill2);
        @(negedge clk);
        id_valid = v; id_opcode = op; id_rs = 5'(rs); id_rt = 5'(rt); mem_zero = z;
        push_exp(ex, mem, wb, ert, ill, st, fl, sc, fc, ill2);
    endtask

    task automatic idle(input logic [3:0] ex, input logic [2:0] mem, input logic [1:0] wb,
                        input int ert, input logic ill, input int sc, input int fc,
                        input logic ill2);
        step(1'b0, R, 0, 0, 1'b0, ex, mem, wb, ert, ill, 1'b0, 1'b0, sc, fc, ill2);
    endtask

    always @(negedge clk or posedge reset) begin : monitor
        exp_t e;
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            check(e.idx, "ex_ctrl", int'(ex_ctrl), int'(e.ex));
            check(e.idx, "mem_ctrl", int'(mem_ctrl), int'(e.mem));
            check(e.idx, "wb_ctrl", int'(wb_ctrl), int'(e.wb));
            check(e.idx, "ex_rt", int'(ex_rt), e.rt);
            check(e.idx, "illegal_op", int'(illegal_op), int'(e.ill));
            check(e.idx, "stall", int'(stall), int'(e.st));
            check(e.idx, "flush", int'(flush), int'(e.fl));
            check(e.idx, "stall_count", int'(stall_count), e.sc);
            check(e.idx, "flush_count", int'(flush_count), e.fc);
            check(e.idx, "dut2_illegal_op", int'(illegal_op2), int'(e.ill2));
            check(e.idx, "dut2_stall", int'(stall2), int'(e.st));
            check(e.idx, "dut2_flush", int'(flush2), int'(e.fl));
            check(e.idx, "dut2_stall_count", int'(stall_count2), (e.sc > 3) ? 3 : e.sc);
            check(e.idx, "dut2_flush_count", int'(flush_count2), (e.fc > 3) ? 3 : e.fc);
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // decode table and stage latency
        step(1, R,    1,  2, 0, 4'b0000, 3'b000, 2'b00,  0, 0, 0, 0, 0, 0, 0);
        step(1, LW,   3,  4, 0, 4'b1100, 3'b000, 2'b00,  2, 0, 0, 0, 0, 0, 0);
        step(1, SW,   6,  7, 0, 4'b0001, 3'b000, 2'b00,  4, 0, 0, 0, 0, 0, 0);
        step(1, BEQ,  8,  9, 0, 4'b0001, 3'b010, 2'b10,  7, 0, 0, 0, 0, 0, 0);
        step(1, ADDI, 10, 11, 0, 4'b0010, 3'b001, 2'b11, 9, 0, 0, 0, 0, 0, 0);
        idle(4'b0001, 3'b100, 2'b00, 11, 0, 0, 0, 1);
        idle(4'b0000, 3'b000, 2'b00, 0, 0, 0, 0, 0);
        idle(4'b0000, 3'b000, 2'b10, 0, 0, 0, 0, 0);
        idle(4'b0000, 3'b000, 2'b00, 0, 0, 0, 0, 0);

        // illegal opcodes
        step(1, BAD,  0, 0, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        idle(4'b0000, 3'b000, 2'b00, 0, 1, 0, 0, 1);
        step(1, ADDI, 0, 0, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        idle(4'b0001, 3'b000, 2'b00, 0, 0, 0, 0, 1);
        idle(4'b0000, 3'b000, 2'b00, 0, 0, 0, 0, 0);
        idle(4'b0000, 3'b000, 2'b10, 0, 0, 0, 0, 0);
        step(0, BAD,  0, 0, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        idle(4'b0000, 3'b000, 2'b00, 0, 0, 0, 0, 0);

        // load-use hazard
        step(1, LW, 1, 5, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        step(1, R,  5, 6, 0, 4'b0001, 3'b000, 2'b00, 5, 0, 1, 0, 0, 0, 0);
        step(1, R,  5, 6, 0, 4'b0000, 3'b010, 2'b00, 0, 0, 0, 0, 1, 0, 0);
        idle(4'b1100, 3'b000, 2'b11, 6, 0, 1, 0, 0);
        idle(4'b0000, 3'b000, 2'b00, 0, 0, 1, 0, 0);
        idle(4'b0000, 3'b000, 2'b10, 0, 0, 1, 0, 0);
        idle(4'b0000, 3'b000, 2'b00, 0, 0, 1, 0, 0);

        // no false hazard: store in EX, and a matching but invalid ID slot
        step(1, SW, 1, 5, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0, 0, 1, 0, 0);
        step(1, R,  5, 6, 0, 4'b0001, 3'b000, 2'b00, 5, 0, 0, 0, 1, 0, 0);
        step(1, LW, 1, 5, 0, 4'b1100, 3'b001, 2'b00, 6, 0, 0, 0, 1, 0, 0);
        step(0, R,  5, 0, 0, 4'b0001, 3'b000, 2'b00, 5, 0, 0, 0, 1, 0, 0);
        idle(4'b0000, 3'b010, 2'b10, 0, 0, 1, 0, 0);
        idle(4'b0000, 3'b000, 2'b11, 0, 0, 1, 0, 0);
        idle(4'b0000, 3'b000, 2'b00, 0, 0, 1, 0, 0);

        // taken branch flushes, then not-taken leaves the pipeline alone
        step(1, BEQ, 1, 2, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0, 0, 1, 0, 0);
        step(1, R,   3, 4, 0, 4'b0010, 3'b000, 2'b00, 2, 0, 0, 0, 1, 0, 0);
        step(1, R,   5, 6, 1, 4'b1100, 3'b100, 2'b00, 4, 0, 0, 1, 1, 0, 0);
        step(1, BEQ, 1, 2, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0, 0, 1, 1, 0);
        step(1, R,   3, 4, 0, 4'b0010, 3'b000, 2'b00, 2, 0, 0, 0, 1, 1, 0);
        step(1, R,   5, 6, 0, 4'b1100, 3'b100, 2'b00, 4, 0, 0, 0, 1, 1, 0);
        idle(4'b1100, 3'b000, 2'b00, 6, 0, 1, 1, 0);
        idle(4'b0000, 3'b000, 2'b10, 0, 0, 1, 1, 0);
        idle(4'b0000, 3'b000, 2'b10, 0, 0, 1, 1, 0);
        idle(4'b0000, 3'b000, 2'b00, 0, 0, 1, 1, 0);

        // hazard and taken branch in the same cycle: flush wins
        step(1, BEQ, 1, 2, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0, 0, 1, 1, 0);
        step(1, LW,  1, 5, 0, 4'b0010, 3'b000, 2'b00, 2, 0, 0, 0, 1, 1, 0);
        step(1, R,   5, 6, 1, 4'b0001, 3'b100, 2'b00, 5, 0, 0, 1, 1, 1, 0);
        idle(4'b0000, 3'b000, 2'b00, 0, 0, 1, 2, 0);

        // five stalls: the 2-bit counter saturates at 3
        step(1, LW, 1, 5, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0, 0, 1, 2, 0);
        for (int k = 0; k < 5; k++) begin
            step(1, LW, 5, 5, 0, 4'b0001, 3'b000, (k == 0) ? 2'b00 : 2'b11, 5, 0, 1, 0,
                 1 + k, 2, 0);
            if (k < 4)
                step(1, LW, 5, 5, 0, 4'b0000, 3'b010, 2'b00, 0, 0, 0, 0, 2 + k, 2, 0);
        end
        idle(4'b0000, 3'b010, 2'b00, 0, 0, 6, 2, 0);
        idle(4'b0000, 3'b000, 2'b11, 0, 0, 6, 2, 0);
        idle(4'b0000, 3'b000, 2'b00, 0, 0, 6, 2, 0);

        // asynchronous reset in the middle of a stall
        step(1, LW, 1, 5, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0, 0, 6, 2, 0);
        step(1, R,  5, 6, 0, 4'b0001, 3'b000, 2'b00, 5, 0, 1, 0, 6, 2, 0);
        #3;
        reset = 1'b1;
        push_exp(4'b0000, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #5;
        reset = 1'b0;
        step(1, R, 1, 2, 0, 4'b0000, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        idle(4'b1100, 3'b000, 2'b00, 2, 0, 0, 0, 0);
        idle(4'b0000, 3'b000, 2'b00, 0, 0, 0, 0, 0);
        idle(4'b0000, 3'b000, 2'b10, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        check(0, "scoreboard_drain", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of stimulus, expected finish before 200000");
        $fatal(1, "simulation time bound exceeded");
    end

endmodule
